// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_LSU    = 1'b1;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_READ_LAT = 1;

    function automatic logic [1:0] port_onehot(input logic port);
        if (port == PORT_IFETCH) begin
            return 2'b01;
        end else begin
            return 2'b10;
        end
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: per-port request handshake plus response.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          resp_valid;
    logic [DATA_W-1:0]   resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not granted last.
module rr_arbiter2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);
    // One-hot grant from the current request vector and the previous winner
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin controller sharing one single-port memory between the
// instruction-fetch and load/store ports; one transaction in flight.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_data_out
);
    localparam int               CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

    arb_state_t        state_r;
    logic              last_grant_r;
    logic              port_r;
    logic              write_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;
    logic              we_r;
    logic              re_r;
    logic [1:0]        resp_valid_r;

    logic [1:0]        grant_s;
    logic [1:0]        ready_s;
    logic              accepting_s;
    logic              sel_port_s;
    logic              sel_write_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    rr_arbiter2 u_rr (
        .req_valid  (bus.req_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    // Accept window, ready gating (forced low while in reset) and winner payload mux
    always_comb begin
        accepting_s = (state_r == IDLE) || (state_r == RESP);
        if (rst_n && accepting_s) begin
            ready_s = grant_s;
        end else begin
            ready_s = 2'b00;
        end
        sel_port_s = grant_s[1];
        if (sel_port_s) begin
            sel_write_s = bus.req_write[1];
            sel_addr_s  = bus.req_addr[2*ADDR_W-1:ADDR_W];
            sel_wdata_s = bus.req_wdata[2*DATA_W-1:DATA_W];
        end else begin
            sel_write_s = bus.req_write[0];
            sel_addr_s  = bus.req_addr[ADDR_W-1:0];
            sel_wdata_s = bus.req_wdata[DATA_W-1:0];
        end
    end

    // Transaction FSM: enables are set on the accepting edge so they are high exactly in ISSUE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= PORT_LSU;
            port_r       <= PORT_IFETCH;
            write_r      <= 1'b0;
            cnt_r        <= CNT_W'(0);
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            rdata_r      <= {DATA_W{1'b0}};
            we_r         <= 1'b0;
            re_r         <= 1'b0;
            resp_valid_r <= 2'b00;
        end else begin
            case (state_r)
                IDLE, RESP: begin
                    resp_valid_r <= 2'b00;
                    if (|ready_s) begin
                        port_r       <= sel_port_s;
                        write_r      <= sel_write_s;
                        addr_r       <= sel_addr_s;
                        wdata_r      <= sel_wdata_s;
                        last_grant_r <= sel_port_s;
                        we_r         <= sel_write_s;
                        re_r         <= ~sel_write_s;
                        state_r      <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    we_r <= 1'b0;
                    re_r <= 1'b0;
                    if (write_r) begin
                        resp_valid_r <= port_onehot(port_r);
                        state_r      <= RESP;
                    end else begin
                        cnt_r   <= CNT_LOAD;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_r == CNT_W'(0)) begin
                        rdata_r      <= mem_data_out;
                        resp_valid_r <= port_onehot(port_r);
                        state_r      <= RESP;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    we_r         <= 1'b0;
                    re_r         <= 1'b0;
                    resp_valid_r <= 2'b00;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = ready_s;
    assign bus.resp_valid    = resp_valid_r;
    assign bus.resp_rdata    = rdata_r;
    assign mem_address       = addr_r;
    assign mem_data_in       = wdata_r;
    assign mem_write_enable  = we_r;
    assign mem_read_enable   = re_r;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin controller that shares the single-port `memory` block (8-bit address, 16-bit data, separate read/write enables) between the instruction-fetch port (port 0) and the load/store port (port 1). It accepts one request at a time via valid/ready, sequences the memory enables for exactly one cycle, waits out the memory read latency, and returns a one-cycle response pulse to the granted requester. It sits between the CPU front-end/LSU and `memory`.

## Interface
Parameters:
- `ADDR_W`, 8: memory address width
- `DATA_W`, 16: memory data width
- `READ_LAT`, 1: cycles from the memory sampling `read_enable` to `data_out` valid; legal range ≥1

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `req_valid` in 2: per-port request valid; bit p = port p
- `req_ready` out 2: per-port accept; at most one bit high
- `req_write` in 2: per-port 1 = write, 0 = read
- `req_addr` in 2*ADDR_W: port p at `[p*ADDR_W +: ADDR_W]`
- `req_wdata` in 2*DATA_W: port p at `[p*DATA_W +: DATA_W]`
- `resp_valid` out 2: one-cycle completion pulse to the granted port (reads and writes)
- `resp_rdata` out DATA_W: read data, valid while `resp_valid` is high for a read
- `mem_address` out ADDR_W, `mem_data_in` out DATA_W, `mem_write_enable` out 1, `mem_read_enable` out 1: to `memory`
- `mem_data_out` in DATA_W: from `memory`

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE/RESP: accepting. Grant picks among asserted `req_valid`; a single requester wins outright; on a tie the port not granted last wins. `req_ready[g]` = accepting & `req_valid[g]`. Handshake at an edge with valid & ready → latch port id, write flag, address, wdata; update last-grant; go to ISSUE. No handshake: RESP→IDLE, IDLE stays.
- ISSUE (1 cycle): drive `mem_address`/`mem_data_in` from latched regs; assert `mem_write_enable` (write) or `mem_read_enable` (read), never both. Write → RESP; read → WAIT.
- WAIT (READ_LAT cycles, down-counter): on the last WAIT edge capture `mem_data_out` into `resp_rdata`; → RESP.
- RESP (1 cycle): `resp_valid[port]` = 1. For writes `resp_rdata` holds its previous value.
- Requesters hold valid and payload stable until ready; valid must not depend on ready. `resp_valid` has no backpressure.
- Only one transaction in flight; requests arriving outside IDLE/RESP wait with ready low.

## Timing
- Reset (rst_n low at an edge): state IDLE, last-grant = port 1 (port 0 wins first tie), counter 0, `mem_*_enable` 0, `mem_address` 0, `mem_data_in` 0, `resp_valid` 0, `resp_rdata` 0. `req_ready` = 0 in any cycle with `rst_n` low.
- Write: handshake at edge E0; enable high in cycle E0–E1; `resp_valid` high in cycle E1–E2.
- Read (READ_LAT=1): handshake E0; ISSUE E0–E1; WAIT E1–E2 (capture at E2); `resp_valid` and data in E2–E3.
- Back-to-back: a new handshake is allowed in RESP, so throughput is one write per 2 cycles and one read per 2+READ_LAT cycles.
- Reset in ISSUE: the memory samples the same edge, so that access still occurs; no response is issued. Reset in WAIT/RESP drops the pending response.
- Both ports continuously valid: grants alternate 0,1,0,1…; no starvation. Worst-case wait is one foreign transaction.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE, ISSUE, WAIT, RESP), port-id constants `PORT_IFETCH=0`, `PORT_LSU=1`, default widths.
- Sub-module `rr_arbiter2`: combinational two-way round-robin pick from `req_valid` and last-grant, outputting a one-hot grant.
- Top holds the FSM, latency counter, and latched request regs.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with both valid → all outputs 0 and no ready. Release → port 0 granted first.
- Port 1 write 0x1234 @0x00, then port 0 read @0x00 → write `resp_valid[1]` 2 cycles after acceptance; read `resp_valid[0]` with `resp_rdata`=0x1234 3 cycles after acceptance.
- Both ports continuously valid, reads @0x10/0x20 preloaded 0xAAAA/0x5555 → grants alternate 0,1,0,1; each response matches its port's data. Enables never both high.
- Port 0 valid arrives during port 1's WAIT → ready stays low until RESP, then accepted in RESP. No idle gap.
- `READ_LAT`=3 build: read @0xFF holding 0xBEEF → `resp_valid` 5 cycles after acceptance, data 0xBEEF.
- Reset asserted during WAIT of a read → no `resp_valid`; after reset, a fresh write/read pair behaves normally.
